handshake_sender: RTL and testbench
===================================

Name: handshake_sender

Overview:
- Upstream stage of the single-word valid/ready receiver.
- Accepts words from a local producer through a write port and buffers them in a DEPTH-entry FIFO.
- Presents one word at a time on a registered valid/data output, holding it until the downstream ready completes the transfer.
- Counts completed transfers and flags dropped writes.

Parameters:
- WIDTH, 8: data word width in bits.
- DEPTH, 4: FIFO entries; power of 2, minimum 2.
- CNT_W, 16: width of the transfer counter.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-low reset.
- wr_en  input  1  producer write strobe.
- wr_data  input  WIDTH  producer write word.
- full  output  1  FIFO holds DEPTH entries.
- empty  output  1  FIFO holds 0 entries.
- level  output  $clog2(DEPTH)+1  FIFO occupancy; excludes the output register.
- overflow  output  1  sticky: a write arrived while full.
- valid  output  1  output word available.
- ready  input  1  downstream accepts the word.
- data  output  WIDTH  output word.
- sent_count  output  CNT_W  completed transfers, modulo 2^CNT_W.
- busy  output  1  high when the FSM is in SEND.

Behaviour:
- Reset: rst sampled low at a rising edge clears, at that edge:
  - state to IDLE; valid, overflow, sent_count and level to 0; empty to 1; full to 0; data to 0; FIFO pointers to 0.
  - Applies mid-transfer too: any held word and all FIFO contents are discarded, and valid is low the following cycle.
- Transfer: occurs at an edge where valid=1 and ready=1.
  - ready is ignored while valid=0.
  - While valid=1 and ready=0, data and valid hold stable.
- Write acceptance:
  - Accepted at an edge when wr_en=1 and full=0; full is the value before that edge.
  - Write while full: word dropped, FIFO unchanged, overflow set to 1 and held until reset.
- FSM, two states:
  - IDLE (valid=0):
    - FIFO non-empty → pop head into data, valid<=1, go to SEND.
    - FIFO empty → stay in IDLE.
  - SEND (valid=1):
    - ready=0 → hold.
    - ready=1 and FIFO non-empty → pop next head into data, valid stays 1, stay in SEND (back-to-back, one word per cycle).
    - ready=1 and FIFO empty → valid<=0, go to IDLE.
- Latency: a word written at edge N into an empty FIFO while in IDLE drives valid=1 after edge N+1. No same-cycle bypass.
- Simultaneous push and pop:
  - In the same edge, level is unchanged and the popped word is the older entry; order is strictly FIFO.
  - When full, the pop still occurs and the write is still rejected, because acceptance uses the pre-edge full.
- level: +1 on an accepted write, −1 on a pop, net 0 when both occur; never exceeds DEPTH.
- sent_count: +1 per transfer; wraps from 2^CNT_W−1 to 0.
- Pointers: wrap modulo DEPTH. full, empty and level are registered and consistent with each other every cycle.
- Total words through the block: at most DEPTH+1 in flight (FIFO plus output register).

Test Plan:
- Single word: reset, then write 0xA5 at edge 1, ready=1 → valid=1 with data=0xA5 after edge 2; transfer at edge 3; valid=0 after it; sent_count=1; level returns to 0.
- Backpressure: write 0x11, 0x22, 0x33 on consecutive edges, ready=0 for 10 cycles → data holds 0x11, level=2. Then ready=1 continuous → 0x11, 0x22, 0x33 on consecutive cycles; valid falls after the third; sent_count=3.
- Overflow: ready=0, write 6 words 0x01..0x06 with DEPTH=4 → one in the output register, 4 in the FIFO, full=1, the sixth dropped, overflow=1. Drain → exactly 0x01..0x05 delivered; overflow stays 1.
- Push/pop same edge when full: FIFO full, valid=1; ready=1 and wr_en=1 (0x77) on the same edge → pop occurs, 0x77 dropped, level=3, overflow=1.
- Reset mid-operation: 3 words queued, valid=1, ready=0; assert rst for one edge → valid=0, level=0, empty=1, sent_count=0, overflow=0. Subsequent ready=1 transfers nothing.
- Counter wrap: CNT_W=4, stream 17 words with ready=1 → sent_count goes 15 → 0 → 1; data order intact.

Source files
------------

// File: rtl/handshake_sender_if.sv
// Downstream valid/ready/data bus between the sender and its receiver.
interface handshake_sender_if #(
    parameter int WIDTH = 8
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );
endinterface

// File: rtl/handshake_sender.sv
// Upstream handshake stage: a producer write port feeds a DEPTH-entry FIFO, and
// a two-state FSM presents one word at a time on a registered valid/data output.
// The FSM holds each word until ready completes the transfer, counts completed
// transfers, and flags writes that arrive while the FIFO is full.
module handshake_sender #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    handshake_sender_if.master       tx,
    output logic [CNT_W-1:0]         sent_count,
    output logic                     busy
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             r_full;
    logic             r_empty;
    logic             r_overflow;
    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic [CNT_W-1:0] r_sent;

    logic             w_push;
    logic             w_pop;
    logic [AW:0]      w_level_nxt;

    // Acceptance uses the pre-edge full flag, so a pop at a full FIFO never
    // makes room for a write on the same edge.
    assign w_push = wr_en && !r_full;
    // Pop whenever the output register is free: empty in IDLE, or being
    // handed off this edge in SEND.
    assign w_pop  = !r_empty && ((r_state == IDLE) || tx.ready);

    // Next occupancy; push and pop together leave the level unchanged.
    always_comb begin
        w_level_nxt = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_nxt = r_level + 1'b1;
            2'b01:   w_level_nxt = r_level - 1'b1;
            default: w_level_nxt = r_level;
        endcase
    end

    // FIFO storage; contents are discarded on reset by clearing the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // FIFO bookkeeping, overflow flag, output FSM and transfer counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
            r_valid    <= 1'b0;
            r_data     <= '0;
            r_sent     <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == LVL_FULL);
            r_empty <= (w_level_nxt == '0);
            if (wr_en && r_full) begin
                r_overflow <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (!r_empty) begin
                        r_data  <= r_mem[r_rd_ptr];
                        r_valid <= 1'b1;
                        r_state <= SEND;
                    end
                end
                SEND: begin
                    if (tx.ready) begin
                        r_sent <= r_sent + 1'b1;
                        if (!r_empty) begin
                            r_data <= r_mem[r_rd_ptr];
                        end else begin
                            r_valid <= 1'b0;
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign full       = r_full;
    assign empty      = r_empty;
    assign level      = r_level;
    assign overflow   = r_overflow;
    assign tx.valid   = r_valid;
    assign tx.data    = r_data;
    assign sent_count = r_sent;
    assign busy       = (r_state == SEND);
endmodule

// File: tb/tb_handshake_sender.sv
// Directed bench for handshake_sender: single word, backpressure, overflow,
// push/pop at full, mid-transfer reset, and counter wrap with CNT_W=4.
module tb_handshake_sender;
    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, wr_en2;
    logic [7:0]  wr_data, wr_data2;
    logic        full, empty, overflow, busy;
    logic        full2, empty2, overflow2, busy2;
    logic [2:0]  level, level2;
    logic [15:0] sent;
    logic [3:0]  sent2;

    int unsigned vectors = 0;
    int unsigned fails   = 0;

    handshake_sender_if #(.WIDTH(8)) bus  ();
    handshake_sender_if #(.WIDTH(8)) bus2 ();

    handshake_sender #(.WIDTH(8), .DEPTH(4), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .full       (full),
        .empty      (empty),
        .level      (level),
        .overflow   (overflow),
        .tx         (bus.master),
        .sent_count (sent),
        .busy       (busy)
    );

    handshake_sender #(.WIDTH(8), .DEPTH(4), .CNT_W(4)) dut_w (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en2),
        .wr_data    (wr_data2),
        .full       (full2),
        .empty      (empty2),
        .level      (level2),
        .overflow   (overflow2),
        .tx         (bus2.master),
        .sent_count (sent2),
        .busy       (busy2)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] exp_d [5];
        int unsigned n;
        logic        v_before;

        rst = 1'b0; wr_en = 1'b0; wr_data = '0; bus.ready = 1'b0;
        wr_en2 = 1'b0; wr_data2 = '0; bus2.ready = 1'b0;
        tick(); tick();

        // Reset state
        chk("rst_valid", bus.valid, 0);
        chk("rst_level", level, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_sent", sent, 0);
        chk("rst_data", bus.data, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b1;

        // Single word
        wr_en = 1'b1; wr_data = 8'hA5; bus.ready = 1'b1;
        tick();
        wr_en = 1'b0;
        chk("sw_valid_e1", bus.valid, 0);
        chk("sw_level_e1", level, 1);
        tick();
        chk("sw_valid_e2", bus.valid, 1);
        chk("sw_data_e2", bus.data, 8'hA5);
        chk("sw_busy_e2", busy, 1);
        chk("sw_level_e2", level, 0);
        tick();
        chk("sw_valid_e3", bus.valid, 0);
        chk("sw_sent_e3", sent, 1);
        chk("sw_empty_e3", empty, 1);

        // Backpressure
        bus.ready = 1'b0;
        wr_en = 1'b1; wr_data = 8'h11; tick();
        wr_data = 8'h22; tick();
        wr_data = 8'h33; tick();
        wr_en = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("bp_valid_hold", bus.valid, 1);
        chk("bp_data_hold", bus.data, 8'h11);
        chk("bp_level_hold", level, 2);
        bus.ready = 1'b1;
        tick();
        chk("bp_data_2", bus.data, 8'h22);
        chk("bp_sent_2", sent, 2);
        tick();
        chk("bp_data_3", bus.data, 8'h33);
        chk("bp_valid_3", bus.valid, 1);
        chk("bp_level_3", level, 0);
        tick();
        chk("bp_valid_end", bus.valid, 0);
        chk("bp_sent_end", sent, 4);

        // Overflow: one word in the output register, four in the FIFO, sixth dropped
        bus.ready = 1'b0;
        wr_en = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            wr_data = 8'(i);
            tick();
        end
        wr_en = 1'b0;
        chk("ov_full", full, 1);
        chk("ov_level", level, 4);
        chk("ov_flag", overflow, 1);
        chk("ov_data_head", bus.data, 8'h01);
        exp_d[0] = 8'h02; exp_d[1] = 8'h03; exp_d[2] = 8'h04; exp_d[3] = 8'h05;
        bus.ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("ov_drain_data", bus.data, exp_d[i]);
            chk("ov_drain_valid", bus.valid, 1);
        end
        tick();
        chk("ov_drain_done", bus.valid, 0);
        chk("ov_sticky", overflow, 1);
        chk("ov_sent", sent, 9);

        // Push and pop on the same edge while full
        rst = 1'b0; tick(); rst = 1'b1;
        chk("pp_ovf_clear", overflow, 0);
        bus.ready = 1'b0;
        wr_en = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            wr_data = 8'(i);
            tick();
        end
        chk("pp_full", full, 1);
        chk("pp_ovf_pre", overflow, 0);
        wr_data = 8'h77; bus.ready = 1'b1;
        tick();
        wr_en = 1'b0;
        chk("pp_level", level, 3);
        chk("pp_ovf", overflow, 1);
        chk("pp_data", bus.data, 8'h02);
        chk("pp_full_after", full, 0);
        exp_d[0] = 8'h03; exp_d[1] = 8'h04; exp_d[2] = 8'h05;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("pp_drain_data", bus.data, exp_d[i]);
        end
        tick();
        chk("pp_no_77", bus.valid, 0);
        chk("pp_sent", sent, 5);

        // Reset mid-operation
        bus.ready = 1'b0;
        wr_en = 1'b1;
        wr_data = 8'hA1; tick();
        wr_data = 8'hA2; tick();
        wr_data = 8'hA3; tick();
        wr_en = 1'b0;
        chk("mr_valid_pre", bus.valid, 1);
        chk("mr_level_pre", level, 2);
        rst = 1'b0; tick(); rst = 1'b1;
        chk("mr_valid", bus.valid, 0);
        chk("mr_level", level, 0);
        chk("mr_empty", empty, 1);
        chk("mr_sent", sent, 0);
        chk("mr_ovf", overflow, 0);
        bus.ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("mr_no_tx_valid", bus.valid, 0);
        chk("mr_no_tx_sent", sent, 0);

        // Counter wrap on the CNT_W=4 instance, 17 words streamed with ready=1
        bus2.ready = 1'b1;
        n = 0;
        for (int i = 0; i < 21; i++) begin
            wr_en2   = (i < 17);
            wr_data2 = 8'h40 + 8'(i);
            v_before = bus2.valid;
            tick();
            if (v_before) n++;
            chk("cw_sent", sent2, 32'(n % 16));
            if (bus2.valid) chk("cw_data", bus2.data, 32'(8'h40 + 8'(n)));
        end
        wr_en2 = 1'b0;
        chk("cw_total", n, 17);
        chk("cw_sent_final", sent2, 1);
        chk("cw_valid_final", bus2.valid, 0);
        chk("cw_ovf", overflow2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
